// File: rtl/systolic_feeder_pkg.sv
// Shared types for the systolic array edge feeder: element width, PE input mux
// select and the feeder's top-level state.
package systolic_feeder_pkg;

    localparam int unsigned NUM_BITS = 8;

    typedef enum logic [1:0] {
        PASSTHROUGH = 2'd0,
        LOAD        = 2'd1,
        PROCESS     = 2'd2
    } input_mux_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WLOAD   = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/systolic_feeder_if.sv
// Weight-row and activation-vector streams into the feeder. The producer uses
// the master modport, the feeder the slave modport.
interface systolic_feeder_if #(
    parameter int unsigned ROWS = 4,
    parameter int unsigned COLS = 4
);
    import systolic_feeder_pkg::*;

    logic                     w_valid;
    logic                     w_ready;
    logic [COLS*NUM_BITS-1:0] w_data;
    logic                     a_valid;
    logic                     a_ready;
    logic [ROWS*NUM_BITS-1:0] a_data;
    logic                     a_last;

    modport master (
        output w_valid, w_data, a_valid, a_data, a_last,
        input  w_ready, a_ready
    );

    modport slave (
        input  w_valid, w_data, a_valid, a_data, a_last,
        output w_ready, a_ready
    );

endinterface

// File: rtl/systolic_feeder_skew_line.sv
// Fixed-depth delay line: d_i appears on q_o DEPTH cycles later; clears to zero.
module skew_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= d_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign q_o = r_pipe[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Edge controller for a weight-stationary PE array: loads weights down the columns,
// then skews activations into the rows and drains. SYSTOLIC_FEEDER_OVALID_EN adds col_valid_o.
module systolic_feeder
    import systolic_feeder_pkg::*;
#(
    parameter int unsigned ROWS = 4,
    parameter int unsigned COLS = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    systolic_feeder_if.slave         bus_if,
    output logic [COLS*NUM_BITS-1:0] top_o,
    output logic [ROWS*NUM_BITS-1:0] left_o,
    output input_mux_t               mux_o,
    output logic [ROWS-1:0]          add_zero_o,
    output logic                     busy_o,
    output logic                     done_o
`ifdef SYSTOLIC_FEEDER_OVALID_EN
    ,
    output logic [COLS-1:0]          col_valid_o
`endif
);

    localparam int unsigned CNT_W = $clog2(ROWS + COLS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(ROWS + COLS - 1);

    feeder_state_t            r_state, w_state_d;
    logic [CNT_W-1:0]         r_cnt, w_cnt_d;
    logic                     r_loaded, w_loaded_d;
    logic [COLS*NUM_BITS-1:0] r_top, w_top_d;
    input_mux_t               r_mux, w_mux_d;
    logic [ROWS-1:0]          r_add_zero, w_add_zero_d;
    logic                     r_done, w_done_d;
    logic                     w_wbeat, w_avec;
    logic [ROWS*NUM_BITS-1:0] w_skew_in;

    // Weights win a simultaneous request in IDLE, so a_ready drops while w_valid is up.
    always_comb begin
        bus_if.w_ready = 1'b0;
        bus_if.a_ready = 1'b0;
        unique case (r_state)
            IDLE: begin
                bus_if.w_ready = 1'b1;
                bus_if.a_ready = r_loaded && !bus_if.w_valid;
            end
            WLOAD:   bus_if.w_ready = 1'b1;
            COMPUTE: bus_if.a_ready = 1'b1;
            DRAIN:   ;
        endcase
    end

    assign w_wbeat = bus_if.w_valid && bus_if.w_ready;
    assign w_avec  = bus_if.a_valid && bus_if.a_ready;

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_loaded_d   = r_loaded;
        w_top_d      = r_top;
        w_mux_d      = r_mux;
        w_add_zero_d = r_add_zero;
        w_done_d     = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_top_d      = '0;
                w_mux_d      = PASSTHROUGH;
                w_add_zero_d = '1;
                if (w_wbeat) begin
                    w_top_d    = bus_if.w_data;
                    w_loaded_d = (ROWS == 1);
                    w_cnt_d    = CNT_W'(1);
                    if (ROWS == 1) begin
                        w_mux_d = LOAD;
                    end else begin
                        w_state_d = WLOAD;
                    end
                end else if (w_avec) begin
                    w_mux_d      = PROCESS;
                    w_add_zero_d = ROWS'(1);
                    w_cnt_d      = '0;
                    w_state_d    = bus_if.a_last ? DRAIN : COMPUTE;
                end
            end
            WLOAD: begin
                // Without a beat, LOAD freezes the column shift; the final LOAD rewrites stationary.
                w_mux_d = LOAD;
                if (w_wbeat) begin
                    w_top_d = bus_if.w_data;
                    if (r_cnt == LAST_BEAT) begin
                        w_state_d  = IDLE;
                        w_loaded_d = 1'b1;
                        w_cnt_d    = '0;
                    end else begin
                        w_mux_d = PASSTHROUGH;
                        w_cnt_d = r_cnt + CNT_W'(1);
                    end
                end
            end
            COMPUTE: begin
                w_top_d      = '0;
                w_mux_d      = PROCESS;
                w_add_zero_d = ROWS'(1);
                if (w_avec && bus_if.a_last) begin
                    w_state_d = DRAIN;
                    w_cnt_d   = '0;
                end
            end
            DRAIN: begin
                w_top_d      = '0;
                w_mux_d      = PROCESS;
                w_add_zero_d = ROWS'(1);
                if (r_cnt == LAST_DRAIN) begin
                    w_done_d  = 1'b1;
                    w_state_d = IDLE;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_loaded   <= 1'b0;
            r_top      <= '0;
            r_mux      <= PASSTHROUGH;
            r_add_zero <= '1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_loaded   <= w_loaded_d;
            r_top      <= w_top_d;
            r_mux      <= w_mux_d;
            r_add_zero <= w_add_zero_d;
            r_done     <= w_done_d;
        end
    end

    assign top_o      = r_top;
    assign mux_o      = r_mux;
    assign add_zero_o = r_add_zero;
    assign busy_o     = (r_state != IDLE);
    assign done_o     = r_done;

    // Idle cycles feed zeros so partial sums pass through untouched.
    assign w_skew_in = w_avec ? bus_if.a_data : '0;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        skew_line #(
            .DEPTH(r + 1),
            .WIDTH(NUM_BITS)
        ) u_skew (
            .clk_i (clk_i),
            .rst_ni(rst_ni),
            .d_i   (w_skew_in[r*NUM_BITS +: NUM_BITS]),
            .q_o   (left_o[r*NUM_BITS +: NUM_BITS])
        );
    end

`ifdef SYSTOLIC_FEEDER_OVALID_EN
    for (genvar c = 0; c < COLS; c++) begin : g_col_vld
        skew_line #(
            .DEPTH(ROWS + c + 1),
            .WIDTH(1)
        ) u_vld (
            .clk_i (clk_i),
            .rst_ni(rst_ni),
            .d_i   (w_avec),
            .q_o   (col_valid_o[c])
        );
    end
`endif

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Edge controller that drives a ROWS×COLS weight-stationary PE array from its top and left edges. It first streams a weight matrix down the columns and issues the LOAD that latches it into every PE. It then streams activation vectors into the left edge with per-row diagonal skew, drives PROCESS and per-row add-zero control, and drains the array before signalling completion. It is the initiator side of the PE array's top/left/control interface.

## Interface
- ROWS, 4, PE rows (≥1)
- COLS, 4, PE columns (≥1)
- NUM_BITS, pkg value, element width
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- w_valid_i / w_ready_o  in/out  1  weight-row handshake
- w_data_i  in  COLS*NUM_BITS  one weight row; column c in bits [c*NUM_BITS +: NUM_BITS]
- a_valid_i / a_ready_o  in/out  1  activation-vector handshake
- a_data_i  in  ROWS*NUM_BITS  one activation vector; element r is for row r
- a_last_i  in  1  marks the final vector of a batch
- top_o  out  COLS*NUM_BITS  to the top_i of row 0
- left_o  out  ROWS*NUM_BITS  to the left_i of column 0, per row
- mux_o  out  input_mux_t  broadcast to all PEs
- add_zero_o  out  ROWS  per-row add_zero
- busy_o  out  1  state ≠ IDLE
- done_o  out  1  one-cycle pulse at the end of DRAIN

## Operation
- Reset values: all data outputs 0; mux_o=PASSTHROUGH; add_zero_o all ones; done_o=0; weights_loaded=0; state IDLE.
- IDLE:
  - Drives mux_o=PASSTHROUGH, top_o=0 and left_o=0.
  - w_ready_o=1.
  - a_ready_o = weights_loaded && !w_valid_i, so weights take priority on simultaneous valid.
  - A w handshake moves to WLOAD. An a handshake moves to COMPUTE.
- WLOAD:
  - Beats b0..b(ROWS-1) arrive in order; b0 is destined for row ROWS-1 and b(ROWS-1) for row 0. A beat counter tracks k.
  - On the handshake of beat k, the next cycle drives top_o=b_k. mux_o is PASSTHROUGH for k<ROWS-1 and LOAD for k=ROWS-1.
  - In a cycle with no handshake, mux_o=LOAD and top_o holds. The PE bottom outputs stay frozen. The garbage latched into stationary is overwritten by the final LOAD.
  - After the final LOAD cycle: weights_loaded=1 and the block returns to IDLE.
- COMPUTE:
  - mux_o=PROCESS and top_o=0. add_zero_o[0]=1; add_zero_o[r>0]=0.
  - a_ready_o=1.
  - An accepted element r enters a skew chain of depth r+1 and reaches left_o[r] r+1 cycles after acceptance.
  - A cycle without a handshake injects a zero vector into the skew chain. Partial sums pass through unchanged.
  - A handshake with a_last_i=1 moves to DRAIN.
- DRAIN:
  - mux_o=PROCESS and zero vectors are injected.
  - A counter runs ROWS+COLS cycles. When it expires, done_o pulses for one cycle and the state returns to IDLE.
- weights_loaded clears only on reset or when a new WLOAD begins.
- Reset mid-operation: asynchronous clear to the reset values above; a partial load is discarded.

## Timing
- Vector accepted at cycle t: left_o[r] carries element r at cycle t+1+r.
- Column c bottom result of that vector is valid at cycle t+ROWS+c+1.
- Weight load takes ROWS handshakes. The minimum load is ROWS cycles followed by an immediate return to IDLE.
- done_o is asserted ROWS+COLS+1 cycles after the a_last handshake.
- Every output is registered except w_ready_o and a_ready_o, which decode from state and a_valid_i/w_valid_i.

## Configuration
- SYSTOLIC_FEEDER_OVALID_EN is defined: adds output col_valid_o[COLS].
  - col_valid_o[c] is high at cycle t+ROWS+c+1 for each real (non-bubble) vector accepted at t.
  - It is implemented as a tagged valid bit travelling alongside the skew chain and drain delay.
- SYSTOLIC_FEEDER_OVALID_EN is undefined: the port and its logic are absent.

## Structure
- pkg holds NUM_BITS, input_mux_t (PASSTHROUGH, LOAD, PROCESS) and a new feeder_state_t (IDLE, WLOAD, COMPUTE, DRAIN).
- Sub-module skew_line(DEPTH, WIDTH) is a reset-to-zero delay shift register.
  - It is instantiated once per row with DEPTH=r+1.
  - It is reused for the col_valid_o delay.

## Test plan
- Reset with rst_ni low mid-WLOAD → all outputs take their reset values, busy_o=0, and a_ready_o=0.
- ROWS=COLS=2, weight rows [1,2] then [3,4], no stalls:
  - top_o shows [1,2] with PASSTHROUGH, then [3,4] with LOAD.
  - Row 1 latches [1,2] and row 0 latches [3,4].
- Same load with a 3-cycle w_valid gap after beat 0 → mux_o=LOAD during the gap, top_o holds [1,2], and the final latched weights are identical.
- Vector [5,6] accepted at t=10 with a_last → left_o[0]=5 at 11; left_o[1]=6 at 12; done_o at 15.
- w_valid_i and a_valid_i both high in IDLE with weights_loaded → the w handshake occurs and a_ready_o=0.
- OVALID_EN build, vectors at t=0 and t=2 with a bubble at t=1 → col_valid_o[0] is high at 3 and 5 only; col_valid_o[1] at 4 and 6.
